// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read/1-write register file with write-through bypass and per-register busy
// scoreboard. Optional macro RF_R0_ZERO_EN hardwires register 0 to zero.
module reg_file_sb #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rA,
   input  logic [ADDR_W-1:0] rB,
   output logic [DATA_W-1:0] aData,
   output logic [DATA_W-1:0] bData,
   output logic              aBusy,
   output logic              bBusy,
   input  logic [ADDR_W-1:0] dR,
   input  logic [DATA_W-1:0] wData,
   input  logic              wEnable,
   input  logic              resEnable,
   input  logic [ADDR_W-1:0] resAddr,
   output logic [ADDR_W:0]   busyCount
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef RF_R0_ZERO_EN
   localparam bit R0Zero = 1'b1;
`else
   localparam bit R0Zero = 1'b0;
`endif

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busyQ, busyD;
   logic [ADDR_W:0]   countQ, countD;

   logic wrEff, resEff;
   logic aHit, bHit;

   // With register 0 hardwired, strobes aimed at it are dropped entirely.
   always_comb begin
      wrEff  = wEnable && !(R0Zero && (dR == '0));
      resEff = resEnable && !(R0Zero && (resAddr == '0));
      aHit   = wrEff && (dR == rA);
      bHit   = wrEff && (dR == rB);
   end

   // Release before reserve so a same-edge collision leaves the register busy.
   always_comb begin
      busyD = busyQ;
      if (wrEff) begin
         busyD[dR] = 1'b0;
      end
      if (resEff) begin
         busyD[resAddr] = 1'b1;
      end
   end

   always_comb begin
      countD = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         countD = countD + {{ADDR_W{1'b0}}, busyD[i]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs[i] <= DATA_W'(i);
         end
         busyQ  <= '0;
         countQ <= '0;
      end else begin
         if (wrEff) begin
            regs[dR] <= wData;
         end
         busyQ  <= busyD;
         countQ <= countD;
      end
   end

   always_comb begin
      if (R0Zero && (rA == '0)) begin
         aData = '0;
      end else if (aHit) begin
         aData = wData;
      end else begin
         aData = regs[rA];
      end

      if (R0Zero && (rB == '0)) begin
         bData = '0;
      end else if (bHit) begin
         bData = wData;
      end else begin
         bData = regs[rB];
      end

      aBusy     = busyQ[rA] & ~aHit;
      bBusy     = busyQ[rB] & ~bHit;
      busyCount = countQ;
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic against
// an array-based reference model. Honours RF_R0_ZERO_EN when defined.
`timescale 1ns/1ps
module tb_reg_file_sb;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

`ifdef RF_R0_ZERO_EN
   localparam bit R0Zero = 1'b1;
`else
   localparam bit R0Zero = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] rA, rB, dR, resAddr;
   logic [DATA_W-1:0] aData, bData, wData;
   logic              aBusy, bBusy, wEnable, resEnable;
   logic [ADDR_W:0]   busyCount;

   reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rA        (rA),
      .rB        (rB),
      .aData     (aData),
      .bData     (bData),
      .aBusy     (aBusy),
      .bBusy     (bBusy),
      .dR        (dR),
      .wData     (wData),
      .wEnable   (wEnable),
      .resEnable (resEnable),
      .resAddr   (resAddr),
      .busyCount (busyCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nCompared = 0;
   int nMismatch = 0;

   logic [DATA_W-1:0] mReg  [DEPTH];
   bit                mBusy [DEPTH];

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatch++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < DEPTH; i++) begin
         mReg[i]  = DATA_W'(i);
         mBusy[i] = 1'b0;
      end
   endtask

   function automatic int modelCount();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(mBusy[i]);
      return n;
   endfunction

   function automatic logic [DATA_W-1:0] expData(input logic [ADDR_W-1:0] a);
      if (R0Zero && a == 0) return '0;
      if (wEnable && !(R0Zero && dR == 0) && dR == a) return wData;
      return mReg[a];
   endfunction

   function automatic logic expBusy(input logic [ADDR_W-1:0] a);
      if (wEnable && !(R0Zero && dR == 0) && dR == a) return 1'b0;
      return mBusy[a];
   endfunction

   task automatic compareAll(input string tag);
      checkVal({tag, ".aData"}, aData, expData(rA));
      checkVal({tag, ".bData"}, bData, expData(rB));
      checkVal({tag, ".aBusy"}, aBusy, expBusy(rA));
      checkVal({tag, ".bBusy"}, bBusy, expBusy(rB));
      checkVal({tag, ".busyCount"}, busyCount, modelCount());
   endtask

   // Drive one cycle's inputs after the falling edge, then compare every output.
   task automatic setInputs(input string tag, input logic rst, input logic we,
                            input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] wd,
                            input logic re, input logic [ADDR_W-1:0] ra,
                            input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
      @(negedge clk);
      rst_n = rst; wEnable = we; dR = d; wData = wd;
      resEnable = re; resAddr = ra; rA = a; rB = b;
      if (!rst) modelReset();
      #1;
      compareAll(tag);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         modelReset();
      end else begin
         if (wEnable && !(R0Zero && dR == 0)) begin
            mReg[dR]  = wData;
            mBusy[dR] = 1'b0;
         end
         if (resEnable && !(R0Zero && resAddr == 0)) mBusy[resAddr] = 1'b1;
      end
   endtask

   initial begin
      logic [ADDR_W-1:0] d, ra, a, b;
      rst_n = 1'b0; wEnable = 1'b0; resEnable = 1'b0;
      dR = '0; wData = '0; resAddr = '0; rA = '0; rB = '0;
      modelReset();
      repeat (2) @(posedge clk);

      // Reset state
      setInputs("rst", 1'b0, 1'b0, 0, 0, 1'b0, 0, 7, 31);
      checkVal("rst_a7", aData, 7);
      checkVal("rst_b31", bData, 31);
      checkVal("rst_cnt", busyCount, 0);
      tick();

      // Bypass
      setInputs("byp", 1'b1, 1'b1, 3, 32'hDEADBEEF, 1'b0, 0, 3, 0);
      checkVal("byp_same", aData, 32'hDEADBEEF);
      tick();
      setInputs("byp2", 1'b1, 1'b0, 0, 0, 1'b0, 0, 3, 0);
      checkVal("byp_after", aData, 32'hDEADBEEF);
      tick();

      // Scoreboard reserve / release
      setInputs("res", 1'b1, 1'b0, 0, 0, 1'b1, 5, 5, 5);
      tick();
      setInputs("res2", 1'b1, 1'b0, 0, 0, 1'b0, 0, 5, 0);
      checkVal("res_busy", aBusy, 1);
      checkVal("res_cnt", busyCount, 1);
      tick();
      setInputs("rel", 1'b1, 1'b1, 5, 32'hAB, 1'b0, 0, 5, 5);
      checkVal("rel_abusy", aBusy, 0);
      checkVal("rel_bbusy", bBusy, 0);
      tick();
      setInputs("rel2", 1'b1, 1'b0, 0, 0, 1'b0, 0, 5, 0);
      checkVal("rel_cnt", busyCount, 0);
      checkVal("rel_data", aData, 32'hAB);
      tick();

      // Same-edge write and reserve of one register
      setInputs("col", 1'b1, 1'b1, 9, 32'h55, 1'b1, 9, 0, 1);
      tick();
      setInputs("col2", 1'b1, 1'b0, 0, 0, 1'b0, 0, 9, 0);
      checkVal("col_data", aData, 32'h55);
      checkVal("col_busy", aBusy, 1);
      checkVal("col_cnt", busyCount, 1);
      tick();

      // Strobes during reset are discarded
      setInputs("rdis", 1'b0, 1'b1, 7, 32'hFFFF, 1'b1, 4, 0, 4);
      tick();
      setInputs("rdis2", 1'b1, 1'b0, 0, 0, 1'b0, 0, 7, 4);
      checkVal("rdis_data", aData, 7);
      checkVal("rdis_busy", bBusy, 0);
      checkVal("rdis_cnt", busyCount, 0);
      tick();

      // Saturation, then asynchronous reset mid-cycle
      for (int i = 0; i < DEPTH; i++) begin
         setInputs("sat", 1'b1, 1'b0, 0, 0, 1'b1, ADDR_W'(i), ADDR_W'(i), 0);
         tick();
      end
      setInputs("sat2", 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 31);
      checkVal("sat_cnt", busyCount, R0Zero ? DEPTH - 1 : DEPTH);
      checkVal("sat_b31", bBusy, 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkVal("mid_cnt", busyCount, 0);
      checkVal("mid_b31", bBusy, 0);
      tick();
      for (int i = 0; i < DEPTH / 2; i++) begin
         setInputs("mid", 1'b0, 1'b0, 0, 0, 1'b0, 0, ADDR_W'(2 * i), ADDR_W'(2 * i + 1));
         checkVal("mid_abusy", aBusy, 0);
         checkVal("mid_bbusy", bBusy, 0);
         tick();
      end

`ifdef RF_R0_ZERO_EN
      setInputs("r0", 1'b1, 1'b1, 0, 32'h1234, 1'b1, 0, 0, 0);
      checkVal("r0_data", aData, 0);
      checkVal("r0_busy", aBusy, 0);
      tick();
      setInputs("r0b", 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0);
      checkVal("r0_cnt", busyCount, 0);
      checkVal("r0_data2", aData, 0);
      tick();
`endif

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         d  = ADDR_W'($urandom_range(0, DEPTH - 1));
         ra = ($urandom_range(0, 3) == 0) ? d : ADDR_W'($urandom_range(0, DEPTH - 1));
         a  = ($urandom_range(0, 2) == 0) ? d : ADDR_W'($urandom_range(0, DEPTH - 1));
         b  = ($urandom_range(0, 2) == 0) ? ra : ADDR_W'($urandom_range(0, DEPTH - 1));
         setInputs("rnd", ($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 4), d,
                   $urandom, ($urandom_range(0, 9) < 4), ra, a, b);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
